// File: rtl/reg_bank_pkg.sv
// Shared types and constants for the two-port register bank arbiter.
package reg_bank_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_DEPTH  = 8;
  localparam int DEF_ADDR_W = 3;
endpackage

// File: rtl/reg_bank.sv
// DEPTH x WIDTH storage: one write port (commits at clock edge when save=1), combinational read.
// Out-of-range addresses drop writes and read as zero; no backpressure.
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              save,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  value,
  output logic [WIDTH-1:0]  rdata
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             in_range;

  assign in_range = (32'(addr) < DEPTH);

  always_comb begin
    mem_d = mem_q;
    if (save && in_range) mem_d[addr] = value;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = in_range ? mem_q[addr] : '0;
endmodule

// File: rtl/reg_bank_arbiter.sv
// Round-robin arbiter serialising port A/B accesses to reg_bank: gnt at +1, rvalid at +2, 3 cycles/txn.
// No queueing: requesters hold req until gnt; req is only sampled while idle.
module reg_bank_arbiter
  import reg_bank_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [WIDTH-1:0]  a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [WIDTH-1:0]  a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [WIDTH-1:0]  b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [WIDTH-1:0]  b_rdata,
  output logic              busy
);
  state_t            state_q, state_d;
  logic              sel_q, sel_d;
  logic              last_q, last_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]  wdata_q, wdata_d;
  logic              a_gnt_q, a_gnt_d, b_gnt_q, b_gnt_d;
  logic              a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
  logic [WIDTH-1:0]  a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic              save;
  logic [WIDTH-1:0]  bank_rdata;

  reg_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_bank (
    .clk   (clk),
    .rst   (rst),
    .save  (save),
    .addr  (addr_q),
    .value (wdata_q),
    .rdata (bank_rdata)
  );

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    last_d     = last_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    a_gnt_d    = 1'b0;
    b_gnt_d    = 1'b0;
    a_rvalid_d = 1'b0;
    b_rvalid_d = 1'b0;
    a_rdata_d  = a_rdata_q;
    b_rdata_d  = b_rdata_q;
    save       = 1'b0;
    case (state_q)
      IDLE: begin
        if (a_req || b_req) begin
          sel_d = (a_req && b_req) ? ~last_q : (b_req ? PORT_B : PORT_A);
          if (sel_d == PORT_A) begin
            we_d    = a_we;
            addr_d  = a_addr;
            wdata_d = a_wdata;
            a_gnt_d = 1'b1;
          end else begin
            we_d    = b_we;
            addr_d  = b_addr;
            wdata_d = b_wdata;
            b_gnt_d = 1'b1;
          end
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        save = we_q;
        // Per-port rdata flops double as the result register so the idle port keeps its last value.
        if (!we_q) begin
          if (sel_q == PORT_A) a_rdata_d = bank_rdata;
          else                 b_rdata_d = bank_rdata;
        end
        a_rvalid_d = (sel_q == PORT_A);
        b_rvalid_d = (sel_q == PORT_B);
        state_d    = RESP;
      end
      RESP: begin
        last_d  = sel_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sel_q      <= PORT_A;
      last_q     <= PORT_B;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      a_gnt_q    <= 1'b0;
      b_gnt_q    <= 1'b0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      last_q     <= last_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      a_gnt_q    <= a_gnt_d;
      b_gnt_q    <= b_gnt_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
    end
  end

  assign a_gnt    = a_gnt_q;
  assign b_gnt    = b_gnt_q;
  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;
  assign a_rdata  = a_rdata_q;
  assign b_rdata  = b_rdata_q;
  assign busy     = (state_q != IDLE);
endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed bench for reg_bank_arbiter; a second DEPTH=6 instance shares the inputs for range checks.
module tb_reg_bank_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic       a_req, a_we, b_req, b_we;
  logic [2:0] a_addr, b_addr;
  logic [7:0] a_wdata, b_wdata;
  logic       a_gnt, a_rvalid, b_gnt, b_rvalid, busy;
  logic [7:0] a_rdata, b_rdata;
  logic       d6_a_gnt, d6_a_rvalid, d6_b_gnt, d6_b_rvalid, d6_busy;
  logic [7:0] d6_a_rdata, d6_b_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_bank_arbiter dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .busy(busy)
  );

  reg_bank_arbiter #(.WIDTH(8), .DEPTH(6), .ADDR_W(3)) dut6 (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(d6_a_gnt), .a_rvalid(d6_a_rvalid), .a_rdata(d6_a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(d6_b_gnt), .b_rvalid(d6_b_rvalid), .b_rdata(d6_b_rdata),
    .busy(d6_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Single-port transaction starting in IDLE with the other port quiet.
  task automatic txn(input logic port, input logic we, input logic [2:0] addr,
                     input logic [7:0] wd, input logic [7:0] exp);
    if (port == 1'b0) begin
      a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd;
    end else begin
      b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd;
    end
    tick();
    chk("txn_gnt",       port ? b_gnt : a_gnt, 1);
    chk("txn_other_gnt", port ? a_gnt : b_gnt, 0);
    chk("txn_busy",      busy, 1);
    a_req = 1'b0; b_req = 1'b0;
    tick();
    chk("txn_rvalid",       port ? b_rvalid : a_rvalid, 1);
    chk("txn_other_rvalid", port ? a_rvalid : b_rvalid, 0);
    chk("txn_gnt_drop",     port ? b_gnt : a_gnt, 0);
    if (!we) chk("txn_rdata", port ? b_rdata : a_rdata, exp);
    tick();
    chk("txn_idle", busy, 0);
  endtask

  // Both ports request in the same IDLE cycle; A is expected to win.
  task automatic contend(input logic awe, input logic [2:0] aad, input logic [7:0] awd,
                         input logic bwe, input logic [2:0] bad, input logic [7:0] bwd,
                         input logic [7:0] aexp, input logic [7:0] bexp);
    a_req = 1'b1; a_we = awe; a_addr = aad; a_wdata = awd;
    b_req = 1'b1; b_we = bwe; b_addr = bad; b_wdata = bwd;
    tick();
    chk("ct_a_gnt", a_gnt, 1);
    chk("ct_b_gnt_lo", b_gnt, 0);
    a_req = 1'b0;
    tick();
    chk("ct_a_rvalid", a_rvalid, 1);
    chk("ct_b_rvalid_lo", b_rvalid, 0);
    if (!awe) chk("ct_a_rdata", a_rdata, aexp);
    tick();
    chk("ct_idle", busy, 0);
    tick();
    chk("ct_b_gnt", b_gnt, 1);
    chk("ct_a_gnt_lo", a_gnt, 0);
    b_req = 1'b0;
    tick();
    chk("ct_b_rvalid", b_rvalid, 1);
    chk("ct_a_rvalid_lo", a_rvalid, 0);
    if (!bwe) chk("ct_b_rdata", b_rdata, bexp);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    tick();
    tick();
    chk("rst_a_gnt", a_gnt, 0);
    chk("rst_b_gnt", b_gnt, 0);
    chk("rst_a_rvalid", a_rvalid, 0);
    chk("rst_b_rvalid", b_rvalid, 0);
    chk("rst_a_rdata", a_rdata, 0);
    chk("rst_b_rdata", b_rdata, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;

    // Basic write then read-back from both ports.
    txn(1'b0, 1'b1, 3'd3, 8'hA5, 8'h00);
    txn(1'b0, 1'b0, 3'd3, 8'h00, 8'hA5);
    txn(1'b1, 1'b0, 3'd3, 8'h00, 8'hA5);

    // Simultaneous writes, last served is B so A goes first.
    contend(1'b1, 3'd1, 8'h11, 1'b1, 3'd2, 8'h22, 8'h00, 8'h00);
    txn(1'b0, 1'b0, 3'd1, 8'h00, 8'h11);
    txn(1'b1, 1'b0, 3'd2, 8'h00, 8'h22);

    // Continuous reads from both ports must alternate A,B,A,B.
    a_req = 1'b1; a_we = 1'b0; a_addr = 3'd1;
    b_req = 1'b1; b_we = 1'b0; b_addr = 3'd2;
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk("rr_a_gnt",    a_gnt,    (i % 6 == 1) ? 1 : 0);
      chk("rr_b_gnt",    b_gnt,    (i % 6 == 4) ? 1 : 0);
      chk("rr_a_rvalid", a_rvalid, (i % 6 == 2) ? 1 : 0);
      chk("rr_b_rvalid", b_rvalid, (i % 6 == 5) ? 1 : 0);
      chk("rr_busy",     busy,     (i % 3 != 0) ? 1 : 0);
      if (i % 6 == 2) chk("rr_a_rdata", a_rdata, 8'h11);
      if (i % 6 == 5) chk("rr_b_rdata", b_rdata, 8'h22);
    end
    a_req = 1'b0; b_req = 1'b0;

    // Cross-port read-after-write.
    txn(1'b1, 1'b1, 3'd5, 8'h3C, 8'h00);
    txn(1'b0, 1'b0, 3'd5, 8'h00, 8'h3C);

    // Reset during ACCESS of a write: outputs clear at once and the write is lost.
    a_req = 1'b1; a_we = 1'b1; a_addr = 3'd6; a_wdata = 8'hFF;
    tick();
    chk("mid_a_gnt", a_gnt, 1);
    rst = 1'b1;
    #1;
    chk("arst_a_gnt", a_gnt, 0);
    chk("arst_busy", busy, 0);
    chk("arst_a_rdata", a_rdata, 0);
    a_req = 1'b0;
    tick();
    rst = 1'b0;
    contend(1'b0, 3'd6, 8'h00, 1'b0, 3'd6, 8'h00, 8'h00, 8'h00);

    // Out-of-range access on the DEPTH=6 instance.
    txn(1'b0, 1'b1, 3'd0, 8'h5A, 8'h00);
    a_req = 1'b1; a_we = 1'b1; a_addr = 3'd7; a_wdata = 8'h55;
    tick();
    chk("oor_w_gnt", d6_a_gnt, 1);
    a_req = 1'b0;
    tick();
    chk("oor_w_rvalid", d6_a_rvalid, 1);
    tick();
    a_req = 1'b1; a_we = 1'b0; a_addr = 3'd7;
    tick();
    chk("oor_r_gnt", d6_a_gnt, 1);
    a_req = 1'b0;
    tick();
    chk("oor_r_rvalid", d6_a_rvalid, 1);
    chk("oor_r_rdata", d6_a_rdata, 8'h00);
    chk("inrange_r_rdata", a_rdata, 8'h55);
    tick();
    txn(1'b0, 1'b0, 3'd0, 8'h00, 8'h5A);
    chk("oor_keep_word0", d6_a_rdata, 8'h5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
